control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus-based CPU. Sits directly upstream of `datapath` and drives every control strobe the datapath consumes: the fetch sequence, ALU/immediate/load/store/branch/jump execute sequences, and the halt state. It replaces hand-driven per-state stimulus with a synchronous Moore/Mealy FSM decoded from IR.

---
 rtl/control_sequencer_pkg.sv | 60 ++++++
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// cpu_defs: opcodes (ALU op == opcode), FSM state encoding, and the
// lookup of the last execute state for each opcode.
package cpu_defs;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    T0       = 4'd1,
    T1       = 4'd2,
    T2       = 4'd3,
    T3       = 4'd4,
    T4       = 4'd5,
    T5       = 4'd6,
    T6       = 4'd7,
    T7       = 4'd8,
    HALT     = 4'd9
  } state_t;

  // Final execute state; unknown opcodes fall through to T3 (nop).
  function automatic state_t last_st(input logic [4:0] op);
    if (op inside {OP_LD, OP_ST})
      return T7;
    if (op inside {OP_MUL, OP_DIV, OP_BR})
      return T6;
    if (op inside {[OP_ADD:OP_ORI], OP_LDI})
      return T5;
    if (op inside {OP_JAL, OP_NEG, OP_NOT})
      return T4;
    return T3;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between sequencer (master) and datapath (slave).
// Inputs: Stop, IR, CON_out. Outputs: all strobes, operation, Run.
interface control_sequencer_if;
  logic        Stop;
  logic [31:0] IR;
  logic        CON_out;
  logic PCout, Zlowout, ZHighout, MDRout;
  logic HIout, LOout, Cout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin;
  logic Yin, HIin, LOin, OutPortin;
  logic IncPC, Read, Write;
  logic GRA, GRB, GRC, Rin, Rout;
  logic BAout, CON_in;
  logic [4:0] operation;
  logic Run;

  modport master (
    input  Stop, IR, CON_out,
    output PCout, Zlowout, ZHighout, MDRout,
    output HIout, LOout, Cout, InPortout,
    output MARin, Zin, PCin, MDRin, IRin,
    output Yin, HIin, LOin, OutPortin,
    output IncPC, Read, Write,
    output GRA, GRB, GRC, Rin, Rout,
    output BAout, CON_in, operation, Run
  );

  modport slave (
    output Stop, IR, CON_out,
    input  PCout, Zlowout, ZHighout, MDRout,
    input  HIout, LOout, Cout, InPortout,
    input  MARin, Zin, PCin, MDRin, IRin,
    input  Yin, HIin, LOin, OutPortin,
    input  IncPC, Read, Write,
    input  GRA, GRB, GRC, Rin, Rout,
    input  BAout, CON_in, operation, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute FSM driving datapath control strobes.
// Ports: Clock, Reset (sync, active-high), bus (control_sequencer_if.master).
module control_sequencer
  import cpu_defs::*;
(
  input  logic Clock,
  input  logic Reset,
  control_sequencer_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_op;
  logic       w_exec;

  assign w_op   = bus.IR[31:27];
  assign w_exec = r_state inside {T3, T4, T5, T6, T7};

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= RESET_ST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RESET_ST: w_next = T0;
      T0:       w_next = T1;
      T1:       w_next = T2;
      T2:       w_next = T3;
      HALT:     w_next = HALT;
      default: begin
        if (w_op == OP_HALT)
          w_next = HALT;
        else if (r_state == last_st(w_op))
          w_next = bus.Stop ? HALT : T0;
        else
          w_next = state_t'(r_state + 4'd1);
      end
    endcase
  end

  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0;
    bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0;
    bus.Cout = 1'b0; bus.InPortout = 1'b0;
    bus.MARin = 1'b0; bus.Zin = 1'b0;
    bus.PCin = 1'b0; bus.MDRin = 1'b0;
    bus.IRin = 1'b0; bus.Yin = 1'b0;
    bus.HIin = 1'b0; bus.LOin = 1'b0;
    bus.OutPortin = 1'b0; bus.IncPC = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0;
    bus.GRA = 1'b0; bus.GRB = 1'b0;
    bus.GRC = 1'b0; bus.Rin = 1'b0;
    bus.Rout = 1'b0; bus.BAout = 1'b0;
    bus.CON_in = 1'b0;
    bus.operation = 5'd0;
    bus.Run = (r_state != HALT);

    unique case (r_state)
      T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1;
        bus.IncPC = 1'b1; bus.PCin = 1'b1;
      end
      T1: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      default: ;
    endcase

    if (w_exec) begin
      unique case (1'b1)
        (w_op inside {[OP_ADD:OP_ORI]}): begin
          unique case (r_state)
            T3: begin
              bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end
            T4: begin
              bus.Zin = 1'b1;
              if (w_op <= OP_SHL) begin
                bus.GRC = 1'b1; bus.Rout = 1'b1;
                bus.operation = w_op;
              end else begin
                bus.Cout = 1'b1;
                bus.operation = (w_op == OP_ADDI) ? OP_ADD :
                                (w_op == OP_ANDI) ? OP_AND : OP_OR;
              end
            end
            T5: begin
              bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1;
            end
            default: ;
          endcase
        end
        (w_op inside {OP_MUL, OP_DIV}): begin
          unique case (r_state)
            T3: begin
              bus.GRA = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end
            T4: begin
              bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
              bus.operation = w_op;
            end
            T5: begin
              bus.Zlowout = 1'b1; bus.LOin = 1'b1;
            end
            T6: begin
              bus.ZHighout = 1'b1; bus.HIin = 1'b1;
            end
            default: ;
          endcase
        end
        (w_op inside {OP_LD, OP_LDI, OP_ST}): begin
          unique case (r_state)
            T3: begin
              bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end
            T4: begin
              bus.Cout = 1'b1; bus.Zin = 1'b1;
              bus.operation = OP_ADD;
            end
            T5: begin
              bus.Zlowout = 1'b1;
              if (w_op == OP_LDI) begin
                bus.GRA = 1'b1; bus.Rin = 1'b1;
              end else begin
                bus.MARin = 1'b1;
              end
            end
            T6: begin
              bus.MDRin = 1'b1;
              if (w_op == OP_ST) begin
                bus.GRA = 1'b1; bus.Rout = 1'b1;
              end else begin
                bus.Read = 1'b1;
              end
            end
            T7: begin
              if (w_op == OP_ST) begin
                bus.Write = 1'b1;
              end else begin
                bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1;
              end
            end
            default: ;
          endcase
        end
        (w_op == OP_BR): begin
          unique case (r_state)
            T3: begin
              bus.GRA = 1'b1; bus.Rout = 1'b1; bus.CON_in = 1'b1;
            end
            T4: begin
              bus.PCout = 1'b1; bus.Yin = 1'b1;
            end
            T5: begin
              bus.Cout = 1'b1; bus.Zin = 1'b1;
              bus.operation = OP_ADD;
            end
            T6: begin
              bus.Zlowout = bus.CON_out;
              bus.PCin = bus.CON_out;
            end
            default: ;
          endcase
        end
        (w_op == OP_JR): begin
          if (r_state == T3) begin
            bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
          end
        end
        (w_op == OP_JAL): begin
          if (r_state == T3) begin
            bus.PCout = 1'b1; bus.GRB = 1'b1; bus.Rin = 1'b1;
          end else if (r_state == T4) begin
            bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
          end
        end
        (w_op inside {OP_MFHI, OP_MFLO, OP_IN}): begin
          if (r_state == T3) begin
            bus.HIout = (w_op == OP_MFHI);
            bus.LOout = (w_op == OP_MFLO);
            bus.InPortout = (w_op == OP_IN);
            bus.GRA = 1'b1; bus.Rin = 1'b1;
          end
        end
        (w_op == OP_OUT): begin
          if (r_state == T3) begin
            bus.GRA = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1;
          end
        end
        (w_op inside {OP_NEG, OP_NOT}): begin
          if (r_state == T3) begin
            bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
            bus.operation = w_op;
          end else if (r_state == T4) begin
            bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors
// from a table, plus reset/halt/stop sequences.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Reset;
  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 Clock = ~Clock;

  typedef bit [32:0] vec_t;

  localparam vec_t PCOUT  = 33'd1 << 32;
  localparam vec_t ZLO    = 33'd1 << 31;
  localparam vec_t ZHI    = 33'd1 << 30;
  localparam vec_t MDROUT = 33'd1 << 29;
  localparam vec_t HIOUT  = 33'd1 << 28;
  localparam vec_t LOOUT  = 33'd1 << 27;
  localparam vec_t COUT   = 33'd1 << 26;
  localparam vec_t INPO   = 33'd1 << 25;
  localparam vec_t MARIN  = 33'd1 << 24;
  localparam vec_t ZIN    = 33'd1 << 23;
  localparam vec_t PCIN   = 33'd1 << 22;
  localparam vec_t MDRIN  = 33'd1 << 21;
  localparam vec_t IRIN   = 33'd1 << 20;
  localparam vec_t YIN    = 33'd1 << 19;
  localparam vec_t HIIN   = 33'd1 << 18;
  localparam vec_t LOIN   = 33'd1 << 17;
  localparam vec_t OUTPI  = 33'd1 << 16;
  localparam vec_t INCPC  = 33'd1 << 15;
  localparam vec_t READ   = 33'd1 << 14;
  localparam vec_t WRITE  = 33'd1 << 13;
  localparam vec_t GRA    = 33'd1 << 12;
  localparam vec_t GRB    = 33'd1 << 11;
  localparam vec_t GRC    = 33'd1 << 10;
  localparam vec_t RIN    = 33'd1 << 9;
  localparam vec_t ROUT   = 33'd1 << 8;
  localparam vec_t BAOUT  = 33'd1 << 7;
  localparam vec_t CONIN  = 33'd1 << 6;
  localparam vec_t RUN    = 33'd1;
  localparam vec_t F0 = PCOUT | MARIN | INCPC | PCIN | RUN;
  localparam vec_t F1 = READ | MDRIN | RUN;
  localparam vec_t F2 = MDROUT | IRIN | RUN;

  function automatic vec_t opv(input logic [4:0] o);
    return {27'd0, o, 1'b0};
  endfunction

  typedef struct {
    string      name;
    logic [4:0] op;
    logic       con;
    int         n;
    vec_t       e [8];
  } rec_t;

  rec_t tbl [20];
  int total = 0;
  int bad = 0;

  function automatic rec_t mk(input string nm, input logic [4:0] op,
      input logic con, input int n, input vec_t e3, input vec_t e4,
      input vec_t e5, input vec_t e6, input vec_t e7);
    rec_t r;
    r.name = nm; r.op = op; r.con = con; r.n = n;
    r.e[0] = F0; r.e[1] = F1; r.e[2] = F2;
    r.e[3] = e3 | RUN; r.e[4] = e4 | RUN; r.e[5] = e5 | RUN;
    r.e[6] = e6 | RUN; r.e[7] = e7 | RUN;
    return r;
  endfunction

  function automatic vec_t got();
    return {bus.PCout, bus.Zlowout, bus.ZHighout, bus.MDRout,
            bus.HIout, bus.LOout, bus.Cout, bus.InPortout,
            bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin,
            bus.Yin, bus.HIin, bus.LOin, bus.OutPortin,
            bus.IncPC, bus.Read, bus.Write,
            bus.GRA, bus.GRB, bus.GRC, bus.Rin, bus.Rout,
            bus.BAout, bus.CON_in, bus.operation, bus.Run};
  endfunction

  task automatic chk(input string nm, input int c, input vec_t exp);
    vec_t g;
    g = got();
    total++;
    if (g !== exp) begin
      bad++;
      $display("FAIL %s cyc%0d got=%h exp=%h", nm, c, g, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk("add", 5'b00011, 0, 6, GRB|ROUT|YIN,
                 GRC|ROUT|ZIN|opv(5'b00011), ZLO|GRA|RIN, 0, 0);
    tbl[1]  = mk("sub", 5'b00100, 0, 6, GRB|ROUT|YIN,
                 GRC|ROUT|ZIN|opv(5'b00100), ZLO|GRA|RIN, 0, 0);
    tbl[2]  = mk("shl", 5'b01011, 0, 6, GRB|ROUT|YIN,
                 GRC|ROUT|ZIN|opv(5'b01011), ZLO|GRA|RIN, 0, 0);
    tbl[3]  = mk("addi", 5'b01100, 0, 6, GRB|ROUT|YIN,
                 COUT|ZIN|opv(5'b00011), ZLO|GRA|RIN, 0, 0);
    tbl[4]  = mk("andi", 5'b01101, 0, 6, GRB|ROUT|YIN,
                 COUT|ZIN|opv(5'b00101), ZLO|GRA|RIN, 0, 0);
    tbl[5]  = mk("ori", 5'b01110, 0, 6, GRB|ROUT|YIN,
                 COUT|ZIN|opv(5'b00110), ZLO|GRA|RIN, 0, 0);
    tbl[6]  = mk("mul", 5'b10000, 0, 7, GRA|ROUT|YIN,
                 GRB|ROUT|ZIN|opv(5'b10000), ZLO|LOIN, ZHI|HIIN, 0);
    tbl[7]  = mk("div", 5'b01111, 0, 7, GRA|ROUT|YIN,
                 GRB|ROUT|ZIN|opv(5'b01111), ZLO|LOIN, ZHI|HIIN, 0);
    tbl[8]  = mk("ld", 5'b00000, 0, 8, GRB|BAOUT|YIN,
                 COUT|ZIN|opv(5'b00011), ZLO|MARIN, READ|MDRIN,
                 MDROUT|GRA|RIN);
    tbl[9]  = mk("ldi", 5'b00001, 0, 6, GRB|BAOUT|YIN,
                 COUT|ZIN|opv(5'b00011), ZLO|GRA|RIN, 0, 0);
    tbl[10] = mk("st", 5'b00010, 0, 8, GRB|BAOUT|YIN,
                 COUT|ZIN|opv(5'b00011), ZLO|MARIN, GRA|ROUT|MDRIN,
                 WRITE);
    tbl[11] = mk("br_t", 5'b10011, 1, 7, GRA|ROUT|CONIN, PCOUT|YIN,
                 COUT|ZIN|opv(5'b00011), ZLO|PCIN, 0);
    tbl[12] = mk("br_f", 5'b10011, 0, 7, GRA|ROUT|CONIN, PCOUT|YIN,
                 COUT|ZIN|opv(5'b00011), 0, 0);
    tbl[13] = mk("jr", 5'b10100, 0, 4, GRA|ROUT|PCIN, 0, 0, 0, 0);
    tbl[14] = mk("jal", 5'b10101, 0, 5, PCOUT|GRB|RIN,
                 GRA|ROUT|PCIN, 0, 0, 0);
    tbl[15] = mk("mfhi", 5'b11001, 0, 4, HIOUT|GRA|RIN, 0, 0, 0, 0);
    tbl[16] = mk("in", 5'b10110, 0, 4, INPO|GRA|RIN, 0, 0, 0, 0);
    tbl[17] = mk("out", 5'b10111, 0, 4, GRA|ROUT|OUTPI, 0, 0, 0, 0);
    tbl[18] = mk("neg", 5'b10001, 0, 5, GRB|ROUT|ZIN|opv(5'b10001),
                 ZLO|GRA|RIN, 0, 0, 0);
    tbl[19] = mk("unk", 5'b11111, 0, 4, 0, 0, 0, 0, 0);

    Reset = 1'b1;
    bus.Stop = 1'b0;
    bus.CON_out = 1'b0;
    bus.IR = 32'h0;
    step();
    step();
    chk("reset_st", 0, RUN);
    Reset = 1'b0;
    step();

    for (int k = 0; k < 20; k++) begin
      bus.IR = {tbl[k].op, 27'h2A5_5C3};
      bus.CON_out = tbl[k].con;
      for (int c = 0; c < tbl[k].n; c++) begin
        chk(tbl[k].name, c, tbl[k].e[c]);
        step();
      end
    end
    chk("back_to_t0", 0, F0);

    // Reset pulse in ld T5
    bus.IR = {5'b00000, 27'h0};
    for (int c = 0; c < 5; c++) begin
      chk("ld_pre", c, tbl[8].e[c]);
      step();
    end
    chk("ld_t5", 5, tbl[8].e[5]);
    Reset = 1'b1;
    step();
    chk("ld_rst", 0, RUN);
    Reset = 1'b0;
    step();
    chk("ld_rst_t0", 0, F0);

    // Stop held during add: halt after T5
    bus.IR = {5'b00011, 27'h0};
    bus.Stop = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("stop_add", c, tbl[0].e[c]);
      step();
    end
    for (int c = 0; c < 12; c++) begin
      chk("halted", c, 33'd0);
      step();
    end
    bus.Stop = 1'b0;
    Reset = 1'b1;
    step();
    chk("halt_rst", 0, RUN);
    Reset = 1'b0;
    step();
    chk("halt_rst_t0", 0, F0);

    // halt opcode
    bus.IR = {5'b11011, 27'h0};
    step();
    chk("halt_t1", 1, F1);
    step();
    chk("halt_t2", 2, F2);
    step();
    chk("halt_t3", 3, RUN);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("halt_op", c, 33'd0);
    end
    Reset = 1'b1;
    step();
    chk("halt_op_rst", 0, RUN);
    Reset = 1'b0;
    step();
    chk("halt_op_t0", 0, F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
